// File: rtl/wb_slv_pkg.sv
// Shared encodings for the Wishbone slave memory: FSM states, response codes, bus geometry.
package wb_slv_pkg;

  localparam int WB_DW = 32;
  localparam int WB_NB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    R_ACK = 2'd0,
    R_ERR = 2'd1,
    R_RTY = 2'd2
  } resp_t;

endpackage

// File: rtl/wb_slv_ram.sv
// Single-port byte-enabled word RAM; write and registered read on the enabled edge.
// Read register clears on rst and otherwise holds until the next enabled read.
module wb_slv_ram
  import wb_slv_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [WB_NB-1:0]     be,
  input  logic [AW-1:0]        addr,
  input  logic [WB_DW-1:0]     wdat,
  output logic [WB_DW-1:0]     rdat
);

  logic [WB_DW-1:0] mem_q [2**AW];
  logic [WB_DW-1:0] rdat_q;

  // Array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < WB_NB; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
    end else if (en && !we) begin
      rdat_q <= mem_q[addr];
    end
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/wb_slv_mem.sv
// Wishbone classic slave memory: response dly+1 cycles after acceptance, one-cycle ack/err/rty.
// Master waits by holding cyc/stb; dropping cyc during wait states aborts without side effects.
module wb_slv_mem
  import wb_slv_pkg::*;
#(
  parameter int          AW    = 10,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          DLY_W = 4,
  parameter int          CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       adr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  input  logic              cyc,
  input  logic              stb,
  input  logic [3:0]        sel,
  input  logic              we,
  output logic              ack,
  output logic              err,
  output logic              rty,
  input  logic [DLY_W-1:0]  dly,
  input  logic              rty_inj,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  state_t           state_q;
  resp_t            code_q;
  logic             we_q;
  logic [AW-1:0]    wadr_q;
  logic [31:0]      din_q;
  logic [3:0]       sel_q;
  logic [DLY_W-1:0] cnt_q;
  logic             ack_q, err_q, rty_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;

  logic             in_win, accept, enter_resp, ram_en;
  resp_t            code_in, cur_code;
  logic             cur_we;
  logic [AW-1:0]    cur_wadr;
  logic [31:0]      cur_din;
  logic [3:0]       cur_sel;
  logic             unused_adr;

  assign unused_adr = &{1'b0, adr[1:0]};

  // Zero-wait accesses hit the RAM on the acceptance edge, so the live bus
  // fields are used in IDLE and the latched copies afterwards.
  always_comb begin
    in_win     = (adr[31:AW+2] == BASE[31:AW+2]);
    accept     = (state_q == IDLE) && cyc && stb;
    code_in    = rty_inj ? R_RTY : (in_win ? R_ACK : R_ERR);
    enter_resp = (accept && (dly == '0)) ||
                 ((state_q == WAIT) && cyc && (cnt_q == DLY_W'(1)));
    cur_code   = code_q;
    cur_we     = we_q;
    cur_wadr   = wadr_q;
    cur_din    = din_q;
    cur_sel    = sel_q;
    if (state_q == IDLE) begin
      cur_code = code_in;
      cur_we   = we;
      cur_wadr = adr[AW+1:2];
      cur_din  = din;
      cur_sel  = sel;
    end
    ram_en = enter_resp && (cur_code == R_ACK) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= R_ACK;
      we_q     <= 1'b0;
      wadr_q   <= '0;
      din_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      ack_q <= enter_resp && (cur_code == R_ACK);
      err_q <= enter_resp && (cur_code == R_ERR);
      rty_q <= enter_resp && (cur_code == R_RTY);
      if (enter_resp && (cur_code == R_ACK)) begin
        if (cur_we) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        else        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            code_q  <= code_in;
            we_q    <= we;
            wadr_q  <= adr[AW+1:2];
            din_q   <= din;
            sel_q   <= sel;
            cnt_q   <= dly;
            state_q <= (dly == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!cyc)                     state_q <= IDLE;
          else if (cnt_q == DLY_W'(1))  state_q <= RESP;
          else                          cnt_q   <= cnt_q - DLY_W'(1);
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_slv_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (cur_we),
    .be   (cur_sel),
    .addr (cur_wadr),
    .wdat (cur_din),
    .rdat (dout)
  );

  assign ack    = ack_q;
  assign err    = err_q;
  assign rty    = rty_q;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;

endmodule
